// File: rtl/chip8_rom_loader.sv
// Boot-time copy engine: streams START_ADDR..END from program ROM into RAM and holds the CPU off.
// Define CHIP8_LOADER_VERIFY_EN to add a read-back verify pass with a sticky verify_err flag.
module chip8_rom_loader #(
    parameter logic [11:0] START_ADDR = 12'h200,
    parameter logic [12:0] LOAD_LEN   = 13'h0E00,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold,
    output logic        verify_err
);

    // Last address copied, clamped so the copy never wraps past 0xFFF.
    localparam logic [12:0] END_FULL = {1'b0, START_ADDR} + LOAD_LEN - 13'd1;
    localparam logic [11:0] END_ADDR = (END_FULL > 13'h0FFF) ? 12'hFFF : END_FULL[11:0];

`ifdef CHIP8_LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StVerify, StVchk, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDone} state_e;
`endif

    state_e      state_q, state_d;
    logic [11:0] rd_q, rd_d;
    logic [11:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        hold_q, hold_d;
    logic        auto_q, auto_d;
    logic        load_go;

    // auto_q stands in for a start request on the first cycle after reset release.
    assign load_go = ((state_q == StIdle) && (start || auto_q)) || ((state_q == StDone) && start);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rd_q    <= START_ADDR;
            wa_q    <= 12'h000;
            wd_q    <= 8'h00;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= AUTO_START;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hold_d  = hold_q;
        auto_d  = auto_q;
        case (state_q)
            StLoad: begin
                // Write stage: the byte read this cycle lands in RAM next cycle.
                we_d = 1'b1;
                wa_d = rd_q;
                wd_d = rom_data;
                if (rd_q == END_ADDR) begin
                    state_d = StFlush;
                end else begin
                    rd_d = rd_q + 12'd1;
                end
            end
            StFlush: begin
`ifdef CHIP8_LOADER_VERIFY_EN
                state_d = StVerify;
                rd_d    = START_ADDR;
`else
                state_d = StDone;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                hold_d  = 1'b0;
`endif
            end
`ifdef CHIP8_LOADER_VERIFY_EN
            StVerify: begin
                if (rd_q == END_ADDR) begin
                    state_d = StVchk;
                end else begin
                    rd_d = rd_q + 12'd1;
                end
            end
            StVchk: begin
                state_d = StDone;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                hold_d  = 1'b0;
            end
`endif
            default: ;
        endcase
        if (load_go) begin
            state_d = StLoad;
            rd_d    = START_ADDR;
            busy_d  = 1'b1;
            hold_d  = 1'b1;
            auto_d  = 1'b0;
        end
    end

`ifdef CHIP8_LOADER_VERIFY_EN
    logic [7:0] vdata_q;
    logic       vvalid_q;
    logic       err_q, err_d;

    // ROM byte is delayed one cycle to line up with the RAM's registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vdata_q  <= 8'h00;
            vvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vdata_q  <= rom_data;
            vvalid_q <= (state_q == StVerify);
            err_q    <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (vvalid_q && (vdata_q != ram_rdata)) begin
            err_d = 1'b1;
        end
        if (load_go) begin
            err_d = 1'b0;
        end
    end

    assign ram_addr   = (state_q == StVerify) ? rd_q : wa_q;
    assign verify_err = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign ram_addr     = wa_q;
    assign verify_err   = 1'b0;
`endif

    assign rom_addr  = rd_q;
    assign ram_we    = we_q;
    assign ram_wdata = wd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cpu_hold  = hold_q;

endmodule

// File: doc/chip8_rom_loader.md
Name: chip8_rom_loader

Overview:
- Boot-time copy engine that sits directly downstream of the CHIP-8 program ROM and upstream of main RAM.
- Reads the ROM one byte per cycle from the program base address and writes each byte into RAM at the same address.
- Holds the CPU off (cpu_hold) until the copy is complete.
- Runs automatically after reset, or on request through a start/done handshake.

Parameters:
- START_ADDR, 12'h200: first address copied, used for both ROM and RAM.
- LOAD_LEN, 13'h0E00: number of bytes to copy. Valid range 1..4096.
- AUTO_START, 1: when 1, a load begins automatically on the first clock after reset release.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE or DONE.
- rom_addr  out  12  address to the ROM (combinational ROM, data valid in the same cycle).
- rom_data  in  8  ROM byte at rom_addr.
- ram_we  out  1  RAM write strobe, one byte per asserted cycle.
- ram_addr  out  12  RAM address, shared by write and verify-read.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, 1-cycle latency (used only with the optional feature).
- busy  out  1  high while a load, or a verify pass, is in progress.
- done  out  1  one-cycle pulse when the operation finishes.
- cpu_hold  out  1  keeps the CPU in reset/stall while high.
- verify_err  out  1  sticky mismatch flag (optional feature only).

Behaviour:
- Reset values: rom_addr=START_ADDR, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, verify_err=0.
  - cpu_hold resets to 1 when AUTO_START=1, else 0.
- States: IDLE, LOAD, FLUSH, (VERIFY, VCHK), DONE.
- Effective end address END = min(START_ADDR+LOAD_LEN-1, 12'hFFF). Addresses never wrap past 0xFFF.
- Entering LOAD:
  - From IDLE when start=1, or on the first cycle after reset release if AUTO_START=1.
  - Also from DONE when start=1, to re-run a load.
  - On entry: rd_addr<=START_ADDR, busy<=1, cpu_hold<=1.
- Two-stage pipeline:
  - Read stage: rom_addr=rd_addr.
  - Write stage, one cycle later: ram_we=1, ram_addr=previous rd_addr, ram_wdata=rom_data sampled at that read.
  - Throughput is one byte per cycle with no bubbles.
- LOAD: rd_addr increments each cycle. When rd_addr==END, the next state is FLUSH.
- FLUSH: the final write is issued, then the block goes to DONE (or VERIFY with the optional feature).
- Timing (start sampled high at cycle 0):
  - First ram_we at cycle 2.
  - Last ram_we at cycle N+1, where N = END-START_ADDR+1.
  - done=1 for exactly cycle N+2; busy and cpu_hold fall at that same cycle.
- DONE: outputs idle, ram_we=0, cpu_hold=0.
- start while busy is ignored; no restart and no queuing.
- reset_n asserted mid-load: everything returns to reset values immediately.
  - A partial RAM image is acceptable.
  - With AUTO_START=1 the load restarts from START_ADDR after reset release.
- ram_we is never high outside LOAD and FLUSH.

Optional Feature:
- Macro: CHIP8_LOADER_VERIFY_EN.
- Defined: after FLUSH the block enters VERIFY, a second pass with ram_we=0.
  - Each cycle it presents ram_addr=rd_addr and rom_addr=rd_addr, and pipelines rom_data one cycle.
  - It compares the pipelined rom_data against ram_rdata.
  - Any mismatch sets verify_err, which stays set until reset or the next start.
  - VCHK absorbs the last compare. done then pulses, so total duration is 2N+3 cycles.
  - busy and cpu_hold stay high throughout.
- Undefined: VERIFY and VCHK are absent, ram_rdata is ignored, and verify_err is tied to 0.

Test Plan:
- AUTO_START=1, LOAD_LEN=18, program ROM → cycles 2..19 write 0x200=0x60, 0x201=0xEA, 0x20B=0x55, 0x211=0x04. done pulses at cycle 20; cpu_hold is 1 before and 0 after.
- AUTO_START=0, start pulse, LOAD_LEN=19 → last write is 0x212=0x00 (ROM default). Exactly 19 ram_we cycles; no write to 0x213.
- START_ADDR=12'hFFE, LOAD_LEN=16 → only 0xFFE and 0xFFF are written. Two ram_we cycles; done at cycle 4; no wrap to 0x000.
- start held high during LOAD, then reset_n low at the 5th write → outputs return to reset values asynchronously. After release with AUTO_START=1, writing restarts at 0x200.
- start re-asserted in DONE → full second load with identical write sequence and a second done pulse.
- CHIP8_LOADER_VERIFY_EN defined, bench RAM model corrupts 0x205 (stores 0x00 instead of 0xAA) → verify_err=1 at done (cycle 2N+3). With an uncorrupted RAM model, verify_err stays 0.
